// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: MIPS instruction-fetch stage that holds the PC, runs the icache req/hit
// handshake, latches the fetched word for decode and computes the next PC.
module pc_fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic [1:0]        PC_src,
    input  logic              PC_EN,
    input  logic              halt,
    input  logic [WORD_W-1:0] rdat1,
    output logic [WORD_W-1:0] instr,
    output logic              instr_valid,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus4,
    output logic              halted
);
    typedef enum logic [1:0] {FETCH, EXEC, HALTED} state_t;
    state_t            r_state, w_next_state;
    logic [WORD_W-1:0] r_pc, r_instr, w_next_pc, w_br_off, w_jr_tgt;
    logic              r_halted;
    assign pc_plus4    = r_pc + 32'd4;
    assign w_br_off    = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_jr_tgt    = rdat1 & ~32'h3;
    assign w_next_pc   = PC_src == 2'b00 ? pc_plus4 :
                         PC_src == 2'b01 ? pc_plus4 + w_br_off :
                         PC_src == 2'b10 ? {pc_plus4[31:28], r_instr[25:0], 2'b00} :
                                           w_jr_tgt;
    // RST gates the request so iREN drops asynchronously even though state is FETCH.
    assign iREN        = r_state == FETCH && !RST;
    assign iaddr       = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_state == EXEC;
    assign halted      = r_halted;
    always_comb begin
        w_next_state = r_state;
        if (r_state == FETCH && ihit) w_next_state = EXEC;
        else if (r_state == EXEC && halt) w_next_state = HALTED;
        else if (r_state == EXEC && PC_EN) w_next_state = FETCH;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= FETCH;
            r_pc     <= PC_INIT;
            r_instr  <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == FETCH && ihit) r_instr <= iload;
            if (r_state == EXEC && !halt && PC_EN) r_pc <= w_next_pc;
            if (r_state == EXEC && halt) r_halted <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed checks of fetch handshake, next-PC selection, stalls, halt and reset.
module tb_pc_fetch_unit;
    logic        CLK = 1'b0, RST = 1'b1, ihit = 1'b0, PC_EN = 1'b0, halt = 1'b0;
    logic [31:0] iload = '0, rdat1 = '0;
    logic [1:0]  PC_src = 2'b00;
    logic        iREN, instr_valid, halted;
    logic [31:0] iaddr, instr, pc, pc_plus4;
    int          checks = 0, errors = 0;

    pc_fetch_unit #(.PC_INIT(32'h0000_0000), .WORD_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .iREN(iREN), .iaddr(iaddr),
        .PC_src(PC_src), .PC_EN(PC_EN), .halt(halt), .rdat1(rdat1), .instr(instr),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .halted(halted)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #3;
        chk("rst_iren", {31'b0, iREN}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rel_iren", {31'b0, iREN}, 32'd1);
        chk("rel_iaddr", iaddr, 32'h0);
        // sequential fetch with single-cycle hits
        ihit = 1'b1; PC_EN = 1'b1; PC_src = 2'b00; iload = 32'h2001_0005;
        tick;
        chk("t1_valid0", {31'b0, instr_valid}, 32'd1);
        chk("t1_iren0", {31'b0, iREN}, 32'd0);
        chk("t1_instr", instr, 32'h2001_0005);
        chk("t1_pc0", pc, 32'h0);
        tick;
        chk("t1_iaddr4", iaddr, 32'h4);
        chk("t1_valid_f", {31'b0, instr_valid}, 32'd0);
        chk("t1_iren4", {31'b0, iREN}, 32'd1);
        tick;
        chk("t1_valid1", {31'b0, instr_valid}, 32'd1);
        tick;
        chk("t1_iaddr8", iaddr, 32'h8);
        tick; tick; tick; tick;
        chk("t2_pc10", iaddr, 32'h10);
        // branch backwards and forwards
        iload = 32'h1000_FFFE; PC_src = 2'b01;
        tick;
        chk("t2_plus4", pc_plus4, 32'h14);
        tick;
        chk("t2_br_back", iaddr, 32'h0C);
        PC_src = 2'b00;
        tick; tick;
        chk("t2_pc10b", iaddr, 32'h10);
        iload = 32'h1000_0003; PC_src = 2'b01;
        tick; tick;
        chk("t2_br_fwd", iaddr, 32'h20);
        // jr to 0x4000_0000, jump, then misaligned jr
        PC_src = 2'b11; rdat1 = 32'h4000_0000;
        tick; tick;
        chk("t3_jr_a", iaddr, 32'h4000_0000);
        iload = 32'h0800_0040; PC_src = 2'b10;
        tick; tick;
        chk("t3_jump", iaddr, 32'h4000_0100);
        PC_src = 2'b11; rdat1 = 32'h0000_1237;
        tick; tick;
        chk("t3_jr_align", iaddr, 32'h0000_1234);
        // icache miss for 5 cycles
        ihit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("t4_wait_iren", {31'b0, iREN}, 32'd1);
            chk("t4_wait_iaddr", iaddr, 32'h1234);
        end
        iload = 32'hABCD_1234; ihit = 1'b1; PC_EN = 1'b0; PC_src = 2'b00;
        tick;
        iload = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t4_stall_pc", pc, 32'h1234);
            chk("t4_stall_instr", instr, 32'hABCD_1234);
            chk("t4_stall_iren", {31'b0, iREN}, 32'd0);
            chk("t4_stall_valid", {31'b0, instr_valid}, 32'd1);
        end
        PC_EN = 1'b1;
        tick;
        chk("t4_resume", iaddr, 32'h1238);
        // halt wins over PC_EN
        iload = 32'hFC00_0000; halt = 1'b1;
        tick; tick;
        chk("t5_halted", {31'b0, halted}, 32'd1);
        chk("t5_pc", pc, 32'h1238);
        chk("t5_iren", {31'b0, iREN}, 32'd0);
        chk("t5_valid", {31'b0, instr_valid}, 32'd0);
        halt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ihit = i[0]; PC_EN = i[1];
            tick;
            chk("t5_stay_halted", {31'b0, halted}, 32'd1);
            chk("t5_stay_iren", {31'b0, iREN}, 32'd0);
        end
        chk("t5_stay_pc", pc, 32'h1238);
        // async reset from halted, then during a fetch with a concurrent hit
        RST = 1'b1;
        #1;
        chk("t6_halt_clr", {31'b0, halted}, 32'd0);
        @(negedge CLK);
        RST = 1'b0; ihit = 1'b0;
        #1;
        chk("t6_fetch_iren", {31'b0, iREN}, 32'd1);
        chk("t6_fetch_iaddr", iaddr, 32'h0);
        ihit = 1'b1; iload = 32'h0000_0055;
        #1;
        RST = 1'b1;
        #1;
        chk("t6_async_iren", {31'b0, iREN}, 32'd0);
        chk("t6_async_valid", {31'b0, instr_valid}, 32'd0);
        tick;
        chk("t6_hit_ignored", instr, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("t6_rel_iaddr", iaddr, 32'h0);
        chk("t6_rel_iren", {31'b0, iREN}, 32'd1);
        // wraparound from 0xFFFF_FFFC
        PC_EN = 1'b1; PC_src = 2'b11; rdat1 = 32'hFFFF_FFFF;
        tick; tick;
        chk("t6_pc_top", iaddr, 32'hFFFF_FFFC);
        chk("t6_plus4_wrap", pc_plus4, 32'h0);
        PC_src = 2'b00;
        tick; tick;
        chk("t6_wrap", iaddr, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
